simd_regfile: RTL and testbench
===============================

SIMD_REGFILE -- requirements
Module: simd_regfile

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 16, giving the bits per lane per register.
REQ-002 The block SHALL have the parameter DEPTH, default 8, giving the number of registers; DEPTH is a power of two and at least 2.
REQ-003 The block SHALL have the parameter LANES, default 4, giving the number of SIMD lanes; AW = clog2(DEPTH).
REQ-004 The block SHALL have the port Clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have the port Reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have the port LD_REG, input, 1 bit: write request.
REQ-007 The block SHALL have the port DR, input, AW bits: write register address.
REQ-008 The block SHALL have the port WR_MASK, input, LANES bits: per-lane write enable.
REQ-009 The block SHALL have the port bus, input, LANES*WIDTH bits: write data; lane i occupies bits [i*WIDTH +: WIDTH].
REQ-010 The block SHALL have the port RD_EN, input, 1 bit: read request.
REQ-011 The block SHALL have the ports SR1 and SR2, input, AW bits each: read addresses.
REQ-012 The block SHALL have the port CLR, input, 1 bit: start-clear pulse.
REQ-013 The block SHALL have the ports SR1_OUT and SR2_OUT, output, LANES*WIDTH bits each: registered read data, packed like bus.
REQ-014 The block SHALL have the port RD_VALID, output, 1 bit: SR1_OUT and SR2_OUT hold data from a read accepted on the previous cycle.
REQ-015 The block SHALL have the port BUSY, output, 1 bit: a clear sweep is in progress.

Function
REQ-016 Storage SHALL be DEPTH x LANES words of WIDTH bits.
REQ-017 When LD_REG=1 and the block is not BUSY, each lane i with WR_MASK[i]=1 SHALL write register DR lane i with bus lane i at the clock edge; unmasked lanes SHALL be unchanged.
REQ-018 When LD_REG=1 and WR_MASK is all zero, the block SHALL write nothing.
REQ-019 A read SHALL be accepted when RD_EN=1 and BUSY=0, with a latency of 1 cycle: SR1_OUT and SR2_OUT SHALL update on the next edge and RD_VALID SHALL be 1 for that one cycle.
REQ-020 When no read is accepted, RD_VALID SHALL be 0 on the next cycle and SR1_OUT and SR2_OUT SHALL hold their previous values.
REQ-021 For a write and read in the same cycle to the same address (SRx==DR, LD_REG=1, not BUSY), the write SHALL be bypassed: SRx_OUT lanes with WR_MASK=1 SHALL take the bus data, and the other lanes SHALL take the stored data.
REQ-022 The bypass of REQ-021 SHALL apply independently to SR1 and SR2, including the case SR1==SR2==DR.
REQ-023 The clear state machine SHALL have the states IDLE and CLEAR, plus a row counter ctr of AW bits.
REQ-024 In IDLE with CLR=1, the next state SHALL be CLEAR with ctr=0.
REQ-025 In CLEAR, each cycle SHALL zero every lane of register ctr and then increment ctr.
REQ-026 When ctr reaches DEPTH-1 in CLEAR, that row SHALL be zeroed and the next state SHALL be IDLE; a sweep therefore lasts exactly DEPTH cycles.
REQ-027 BUSY SHALL equal 1 exactly while the state is CLEAR.
REQ-028 CLR asserted while in CLEAR SHALL be ignored, with no restart.
REQ-029 While BUSY=1, LD_REG and RD_EN SHALL be ignored: no write, RD_VALID=0, outputs held.
REQ-030 When CLR=1 and LD_REG=1 occur together in IDLE, the write SHALL complete this cycle and the sweep SHALL start next cycle, so the written row is later zeroed.
REQ-031 When CLR=1 and RD_EN=1 occur together in IDLE, the read SHALL be accepted using pre-clear data.

Reset
REQ-032 When Reset=1 at a clock edge, all DEPTH*LANES words SHALL become 0 in that single cycle.
REQ-033 When Reset=1 at a clock edge, the state SHALL become IDLE, ctr=0, BUSY=0, RD_VALID=0, SR1_OUT=0 and SR2_OUT=0.
REQ-034 Reset SHALL take priority over CLR, LD_REG and RD_EN, including when it arrives during a CLEAR sweep.
REQ-035 The first operation after Reset deasserts SHALL be accepted on the very next cycle.

Verification
REQ-036 The bench SHALL cover write/read-back: with defaults, write DR=3, mask 4'b1111, bus=64'h4444_3333_2222_1111; next cycle RD_EN, SR1=3 -> one cycle later SR1_OUT=64'h4444_3333_2222_1111 and RD_VALID=1.
REQ-037 The bench SHALL cover masked write: from REQ-036, write DR=3, mask 4'b0101, bus=64'hFFFF_FFFF_FFFF_FFFF -> a read of SR2=3 returns 64'h4444_FFFF_2222_FFFF.
REQ-038 The bench SHALL cover bypass: in the same cycle, write DR=5, mask 4'b0011, bus=64'hAAAA_BBBB_CCCC_DDDD with stored row 5=0, and RD_EN with SR1=SR2=5 -> next cycle both outputs=64'h0000_0000_CCCC_DDDD.
REQ-039 The bench SHALL cover the clear sweep: fill all rows non-zero, then pulse CLR -> BUSY=1 for exactly 8 cycles; RD_EN and LD_REG during BUSY leave RD_VALID=0 and storage unchanged; afterwards all rows read 0.
REQ-040 The bench SHALL cover reset mid-sweep: pulse CLR, then assert Reset after 3 sweep cycles -> the next cycle has BUSY=0, all outputs 0 and all rows 0; a write and read issued the cycle after Reset is released succeed.
REQ-041 The bench SHALL cover simultaneous CLR and LD_REG: CLR and LD_REG with DR=7 in IDLE -> row 7 is written, then BUSY rises next cycle, and row 7 reads 0 after the sweep.

Source files
------------

// File: rtl/simd_regfile.sv
// rtl/simd_regfile.sv - SIMD register file with per-lane write masks, bypassed dual reads, and a background clear sweep
module simd_regfile #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int LANES = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   LD_REG,
  input  logic [AW-1:0]          DR,
  input  logic [LANES-1:0]       WR_MASK,
  input  logic [LANES*WIDTH-1:0] bus,
  input  logic                   RD_EN,
  input  logic [AW-1:0]          SR1,
  input  logic [AW-1:0]          SR2,
  input  logic                   CLR,
  output logic [LANES*WIDTH-1:0] SR1_OUT,
  output logic [LANES*WIDTH-1:0] SR2_OUT,
  output logic                   RD_VALID,
  output logic                   BUSY
);

  localparam int DW = LANES * WIDTH;
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_CLEAR = 1'b1;
  localparam logic [AW-1:0] LAST_ROW = AW'(DEPTH - 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic          state_q, state_d;
  logic [AW-1:0] ctr_q, ctr_d;
  logic [DW-1:0] sr1_out_q, sr1_out_d;
  logic [DW-1:0] sr2_out_q, sr2_out_d;
  logic          rd_valid_q, rd_valid_d;

  logic wr_en;
  logic rd_acc;

  // Writes and reads are only honoured while the sweep is not running.
  assign wr_en  = (state_q == ST_IDLE) && LD_REG;
  assign rd_acc = (state_q == ST_IDLE) && RD_EN;

  always_comb begin
    mem_d      = mem_q;
    state_d    = state_q;
    ctr_d      = ctr_q;
    sr1_out_d  = sr1_out_q;
    sr2_out_d  = sr2_out_q;
    rd_valid_d = rd_acc;

    if (rd_acc) begin
      sr1_out_d = mem_q[SR1];
      sr2_out_d = mem_q[SR2];
    end

    // Masked lanes of a same-cycle write are forwarded to matching read ports.
    for (int i = 0; i < LANES; i++) begin
      if (wr_en && WR_MASK[i]) begin
        mem_d[DR][i*WIDTH +: WIDTH] = bus[i*WIDTH +: WIDTH];
        if (rd_acc && (SR1 == DR)) sr1_out_d[i*WIDTH +: WIDTH] = bus[i*WIDTH +: WIDTH];
        if (rd_acc && (SR2 == DR)) sr2_out_d[i*WIDTH +: WIDTH] = bus[i*WIDTH +: WIDTH];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (CLR) begin
          state_d = ST_CLEAR;
          ctr_d   = '0;
        end
      end
      default: begin
        mem_d[ctr_q] = '0;
        ctr_d        = ctr_q + 1'b1;
        if (ctr_q == LAST_ROW) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
      state_q    <= ST_IDLE;
      ctr_q      <= '0;
      sr1_out_q  <= '0;
      sr2_out_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      state_q    <= state_d;
      ctr_q      <= ctr_d;
      sr1_out_q  <= sr1_out_d;
      sr2_out_q  <= sr2_out_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign SR1_OUT  = sr1_out_q;
  assign SR2_OUT  = sr2_out_q;
  assign RD_VALID = rd_valid_q;
  assign BUSY     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_simd_regfile.sv
// tb/tb_simd_regfile.sv - scoreboard bench for simd_regfile
module tb_simd_regfile;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int LANES = 4;
  localparam int AW    = 3;
  localparam int DW    = LANES * WIDTH;

  logic          Clk;
  logic          Reset;
  logic          LD_REG;
  logic [AW-1:0] DR;
  logic [LANES-1:0] WR_MASK;
  logic [DW-1:0] bus;
  logic          RD_EN;
  logic [AW-1:0] SR1;
  logic [AW-1:0] SR2;
  logic          CLR;
  logic [DW-1:0] SR1_OUT;
  logic [DW-1:0] SR2_OUT;
  logic          RD_VALID;
  logic          BUSY;

  simd_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(LANES)) dut (
    .Clk(Clk), .Reset(Reset), .LD_REG(LD_REG), .DR(DR), .WR_MASK(WR_MASK),
    .bus(bus), .RD_EN(RD_EN), .SR1(SR1), .SR2(SR2), .CLR(CLR),
    .SR1_OUT(SR1_OUT), .SR2_OUT(SR2_OUT), .RD_VALID(RD_VALID), .BUSY(BUSY)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] ref_mem [DEPTH];
  int            tests_run    = 0;
  int            tests_failed = 0;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [LANES-1:0] m,
                                          input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < LANES; i++)
      if (m[i]) r[i*WIDTH +: WIDTH] = d[i*WIDTH +: WIDTH];
    return r;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    LD_REG = 0; DR = '0; WR_MASK = '0; bus = '0;
    RD_EN = 0; SR1 = '0; SR2 = '0; CLR = 0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [LANES-1:0] m, input logic [DW-1:0] d);
    LD_REG = 1; DR = a; WR_MASK = m; bus = d;
    ref_mem[a] = merge(ref_mem[a], m, d);
    tick();
    idle_inputs();
  endtask

  task automatic do_read(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    exp_t e;
    e.e1 = ref_mem[a1];
    e.e2 = ref_mem[a2];
    sb_q.push_back(e);
    RD_EN = 1; SR1 = a1; SR2 = a2;
    tick();
    idle_inputs();
  endtask

  task automatic clear_model();
    for (int r = 0; r < DEPTH; r++) ref_mem[r] = '0;
  endtask

  task automatic test_reset();
    Reset = 1;
    tick();
    Reset = 0;
    clear_model();
    tests_run++;
    if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    tests_run++;
    if (RD_VALID !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_valid: got %b expected 0", RD_VALID); end
    tests_run++;
    if (SR1_OUT !== '0 || SR2_OUT !== '0) begin
      tests_failed++; $display("FAIL reset_outs: got %h/%h expected 0/0", SR1_OUT, SR2_OUT);
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    do_write(3'd3, 4'b1111, 64'h4444_3333_2222_1111);
    do_read(3'd3, 3'd0);
    e = sb_q.pop_front();
    tests_run++;
    if (RD_VALID !== 1'b1) begin tests_failed++; $display("FAIL wr_rd_valid: got %b expected 1", RD_VALID); end
    tests_run++;
    if (SR1_OUT !== 64'h4444_3333_2222_1111 || SR1_OUT !== e.e1 || SR2_OUT !== e.e2) begin
      tests_failed++; $display("FAIL wr_rd_data: got %h/%h expected %h/%h", SR1_OUT, SR2_OUT, e.e1, e.e2);
    end
    tick();
    tests_run++;
    if (RD_VALID !== 1'b0 || SR1_OUT !== e.e1) begin
      tests_failed++; $display("FAIL wr_rd_hold: got valid=%b %h expected valid=0 %h", RD_VALID, SR1_OUT, e.e1);
    end
  endtask

  task automatic test_masked_write();
    exp_t e;
    do_write(3'd3, 4'b0101, 64'hFFFF_FFFF_FFFF_FFFF);
    do_read(3'd0, 3'd3);
    e = sb_q.pop_front();
    tests_run++;
    if (SR2_OUT !== 64'h4444_FFFF_2222_FFFF || SR2_OUT !== e.e2 || RD_VALID !== 1'b1) begin
      tests_failed++; $display("FAIL masked_write: got %h expected %h", SR2_OUT, e.e2);
    end
    do_write(3'd3, 4'b0000, 64'h1234_5678_9ABC_DEF0);
    do_read(3'd3, 3'd3);
    e = sb_q.pop_front();
    tests_run++;
    if (SR1_OUT !== e.e1 || SR2_OUT !== 64'h4444_FFFF_2222_FFFF) begin
      tests_failed++; $display("FAIL zero_mask: got %h expected %h", SR1_OUT, e.e1);
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    e.e1 = merge(ref_mem[5], 4'b0011, 64'hAAAA_BBBB_CCCC_DDDD);
    e.e2 = e.e1;
    sb_q.push_back(e);
    LD_REG = 1; DR = 3'd5; WR_MASK = 4'b0011; bus = 64'hAAAA_BBBB_CCCC_DDDD;
    RD_EN = 1; SR1 = 3'd5; SR2 = 3'd5;
    ref_mem[5] = e.e1;
    tick();
    idle_inputs();
    e = sb_q.pop_front();
    tests_run++;
    if (SR1_OUT !== 64'h0000_0000_CCCC_DDDD || SR2_OUT !== 64'h0000_0000_CCCC_DDDD || RD_VALID !== 1'b1) begin
      tests_failed++; $display("FAIL bypass: got %h/%h expected %h", SR1_OUT, SR2_OUT, e.e1);
    end
    do_read(3'd5, 3'd3);
    e = sb_q.pop_front();
    tests_run++;
    if (SR1_OUT !== e.e1 || SR2_OUT !== e.e2) begin
      tests_failed++; $display("FAIL bypass_stored: got %h/%h expected %h/%h", SR1_OUT, SR2_OUT, e.e1, e.e2);
    end
  endtask

  task automatic test_clear();
    exp_t e;
    int cnt;
    logic [DW-1:0] held;
    for (int r = 0; r < DEPTH; r++) do_write(AW'(r), 4'b1111, {4{16'h1000 + 16'(r)}});
    do_read(3'd1, 3'd2);
    e = sb_q.pop_front();
    held = SR1_OUT;
    tests_run++;
    if (SR1_OUT !== e.e1 || SR2_OUT !== e.e2) begin
      tests_failed++; $display("FAIL fill_read: got %h/%h expected %h/%h", SR1_OUT, SR2_OUT, e.e1, e.e2);
    end
    CLR = 1;
    tick();
    cnt = 0;
    // Row 0 is cleared first, so a write that slipped through would survive the sweep.
    while (BUSY === 1'b1 && cnt < 20) begin
      CLR = 1; LD_REG = 1; DR = 3'd0; WR_MASK = 4'b1111; bus = '1;
      RD_EN = 1; SR1 = 3'd4; SR2 = 3'd4;
      tick();
      cnt++;
      tests_run++;
      if (RD_VALID !== 1'b0 || SR1_OUT !== held) begin
        tests_failed++; $display("FAIL busy_ignore: got valid=%b %h expected valid=0 %h", RD_VALID, SR1_OUT, held);
      end
    end
    idle_inputs();
    clear_model();
    tests_run++;
    if (cnt != 8) begin tests_failed++; $display("FAIL busy_len: got %0d expected 8", cnt); end
    for (int r = 0; r < DEPTH; r++) begin
      do_read(AW'(r), AW'(DEPTH - 1 - r));
      e = sb_q.pop_front();
      tests_run++;
      if (SR1_OUT !== e.e1 || SR2_OUT !== e.e2 || RD_VALID !== 1'b1) begin
        tests_failed++; $display("FAIL clear_row%0d: got %h/%h expected %h/%h", r, SR1_OUT, SR2_OUT, e.e1, e.e2);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    exp_t e;
    for (int r = 0; r < DEPTH; r++) do_write(AW'(r), 4'b1111, {4{16'hA000 + 16'(r)}});
    do_read(3'd4, 3'd6);
    e = sb_q.pop_front();
    tests_run++;
    if (SR1_OUT !== e.e1 || SR2_OUT !== e.e2) begin
      tests_failed++; $display("FAIL pre_sweep_read: got %h/%h expected %h/%h", SR1_OUT, SR2_OUT, e.e1, e.e2);
    end
    CLR = 1;
    tick();
    CLR = 0;
    tick(); tick(); tick();
    tests_run++;
    if (BUSY !== 1'b1) begin tests_failed++; $display("FAIL mid_sweep_busy: got %b expected 1", BUSY); end
    Reset = 1;
    tick();
    Reset = 0;
    clear_model();
    tests_run++;
    if (BUSY !== 1'b0 || RD_VALID !== 1'b0 || SR1_OUT !== '0 || SR2_OUT !== '0) begin
      tests_failed++;
      $display("FAIL mid_reset: got busy=%b valid=%b %h/%h expected 0 0 0/0", BUSY, RD_VALID, SR1_OUT, SR2_OUT);
    end
    e.e1 = 64'h5555_6666_7777_8888;
    e.e2 = ref_mem[2];
    sb_q.push_back(e);
    LD_REG = 1; DR = 3'd1; WR_MASK = 4'b1111; bus = 64'h5555_6666_7777_8888;
    RD_EN = 1; SR1 = 3'd1; SR2 = 3'd2;
    ref_mem[1] = 64'h5555_6666_7777_8888;
    tick();
    idle_inputs();
    e = sb_q.pop_front();
    tests_run++;
    if (RD_VALID !== 1'b1 || SR1_OUT !== e.e1 || SR2_OUT !== e.e2) begin
      tests_failed++; $display("FAIL post_reset_op: got %h/%h expected %h/%h", SR1_OUT, SR2_OUT, e.e1, e.e2);
    end
    for (int r = 0; r < DEPTH; r++) begin
      do_read(AW'(r), AW'(r));
      e = sb_q.pop_front();
      tests_run++;
      if (SR1_OUT !== e.e1 || SR2_OUT !== e.e2) begin
        tests_failed++; $display("FAIL reset_row%0d: got %h expected %h", r, SR1_OUT, e.e1);
      end
    end
  endtask

  task automatic test_clr_with_write();
    exp_t e;
    int cnt;
    do_write(3'd6, 4'b1111, 64'h0606_0606_0606_0606);
    e.e1 = 64'h7777_7777_7777_7777;
    e.e2 = ref_mem[6];
    sb_q.push_back(e);
    CLR = 1; LD_REG = 1; DR = 3'd7; WR_MASK = 4'b1111; bus = 64'h7777_7777_7777_7777;
    RD_EN = 1; SR1 = 3'd7; SR2 = 3'd6;
    tick();
    idle_inputs();
    e = sb_q.pop_front();
    tests_run++;
    if (RD_VALID !== 1'b1 || SR1_OUT !== e.e1 || SR2_OUT !== e.e2) begin
      tests_failed++; $display("FAIL clr_rd_preclear: got %h/%h expected %h/%h", SR1_OUT, SR2_OUT, e.e1, e.e2);
    end
    tests_run++;
    if (BUSY !== 1'b1) begin tests_failed++; $display("FAIL clr_ld_busy: got %b expected 1", BUSY); end
    cnt = 0;
    while (BUSY === 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    clear_model();
    tests_run++;
    if (cnt != 8) begin tests_failed++; $display("FAIL clr_ld_len: got %0d expected 8", cnt); end
    do_read(3'd7, 3'd6);
    e = sb_q.pop_front();
    tests_run++;
    if (SR1_OUT !== e.e1 || SR2_OUT !== e.e2 || RD_VALID !== 1'b1) begin
      tests_failed++; $display("FAIL clr_ld_row7: got %h/%h expected %h/%h", SR1_OUT, SR2_OUT, e.e1, e.e2);
    end
  endtask

  initial begin
    Reset = 0;
    idle_inputs();
    clear_model();
    test_reset();
    test_write_read();
    test_masked_write();
    test_bypass();
    test_clear();
    test_reset_mid_sweep();
    test_clr_with_write();
    tests_run++;
    if (sb_q.size() != 0) begin tests_failed++; $display("FAIL sb_leftover: got %0d expected 0", sb_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
